// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
package nibble_serial_addsub_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_SLICE = 4;
  localparam int unsigned NSLICE    = DEF_WIDTH / DEF_SLICE;
  localparam int unsigned IDX_W     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_addsub_adder_slice.sv
// adder_slice: W-bit ripple-carry adder built from a chain of full-adder cells.
// Also exposes the carry into the top bit so the caller can form overflow.
module nibble_serial_addsub_adder_slice #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W:0] c;

  assign c[0] = cin;

  // One full-adder cell per bit, carries rippling upward.
  for (genvar i = 0; i < int'(W); i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout     = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: WIDTH-bit add/subtract computed SLICE bits per cycle
// through one shared ripple slice, with the carry held in a register.
// Optional feature macro: ADDSUB_ZERO_FLAG_EN adds a registered 'zero' output.
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
`ifdef ADDSUB_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic             overflow
);

  localparam int unsigned NS  = WIDTH / SLICE;
  localparam int unsigned IW  = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [SLICE-1:0] SLICE_MASK = {SLICE{1'b1}};

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
`ifdef ADDSUB_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  logic [31:0]      base;
  logic [SLICE-1:0] a_sl, b_sl, s_sum;
  logic             s_cout, s_cmsb;
  logic             last;

  // Select the current slice of each latched operand.
  always_comb begin
    base = 32'(idx_q) * 32'(SLICE);
    a_sl = SLICE'(a_q >> base);
    b_sl = SLICE'(b_q >> base);
    last = (idx_q == IW'(NS - 1));
  end

  nibble_serial_addsub_adder_slice #(.W(SLICE)) u_adder_slice (
    .a        (a_sl),
    .b        (b_sl),
    .cin      (carry_q),
    .sum      (s_sum),
    .cout     (s_cout),
    .c_msb_in (s_cmsb)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last)      state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Datapath and handshake outputs, computed from current and next state.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
`ifdef ADDSUB_ZERO_FLAG_EN
    zero_d      = zero_q;
`endif
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        sum_d   = (sum_q & ~(WIDTH'(SLICE_MASK) << base)) | (WIDTH'(s_sum) << base);
        carry_d = s_cout;
        if (last) begin
          carry_out_d = s_cout;
          overflow_d  = s_cmsb ^ s_cout;
`ifdef ADDSUB_ZERO_FLAG_EN
          zero_d      = (sum_d == '0);
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ADDSUB_ZERO_FLAG_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef ADDSUB_ZERO_FLAG_EN
      zero_q      <= zero_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
`ifdef ADDSUB_ZERO_FLAG_EN
  assign zero      = zero_q;
`endif

endmodule
